// File: rtl/fcmp_arb_if.sv
// Bus bundle for the two-requester float-compare arbiter: two request
// channels and one result channel.
interface fcmp_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_x1;
  logic [31:0] req0_x2;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_x1;
  logic [31:0] req1_x2;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;

  modport master (
    output req0_valid, req0_op, req0_x1, req0_x2,
    input  req0_ready,
    output req1_valid, req1_op, req1_x1, req1_x2,
    input  req1_ready,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_x1, req0_x2,
    output req0_ready,
    input  req1_valid, req1_op, req1_x1, req1_x2,
    output req1_ready,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/fcmp_arb.sv
// Two requesters share one single-precision compare datapath (feq/flt/fle)
// and a one-entry result register, arbitrated round-robin.
module fcmp_arb (
  input  logic        clk,
  input  logic        rstn,
  fcmp_arb_if.slave   bus,
  output logic        dbg_full,
  output logic        dbg_last_grant
);

  // Handshake: a channel transfers on any rising edge where valid & ready;
  // the sender holds valid and payload stable until that edge, and ready
  // never depends on payload.

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e      state;
  logic        last_grant;
  logic [31:0] data_q;
  logic        id_q;

  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        xfer;

  logic [1:0]  sel_op;
  logic [31:0] sel_x1;
  logic [31:0] sel_x2;
  logic [31:0] key1;
  logic [31:0] key2;
  logic        outcome;

  // Monotonic unsigned key: both zeros collapse to the midpoint, positives
  // sit above it, negatives below with magnitude order inverted.
  function automatic logic [31:0] fkey(input logic [31:0] v);
    logic [31:0] k;
    if (v[30:0] == 31'd0)
      k = {1'b1, 31'd0};
    else if (!v[31])
      k = {1'b1, v[30:0]};
    else
      k = {1'b0, ~v[30:0]};
    return k;
  endfunction

  assign slot_free = (state == S_EMPTY) | bus.resp_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstn && slot_free) begin
      if (bus.req0_valid && !bus.req1_valid) begin
        grant0 = 1'b1;
      end else if (!bus.req0_valid && bus.req1_valid) begin
        grant1 = 1'b1;
      end else if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end
    end
  end

  assign xfer = grant0 | grant1;

  always_comb begin
    if (grant1) begin
      sel_op = bus.req1_op;
      sel_x1 = bus.req1_x1;
      sel_x2 = bus.req1_x2;
    end else begin
      sel_op = bus.req0_op;
      sel_x1 = bus.req0_x1;
      sel_x2 = bus.req0_x2;
    end
  end

  assign key1 = fkey(sel_x1);
  assign key2 = fkey(sel_x2);

  always_comb begin
    outcome = 1'b0;
    case (sel_op)
      2'b00:   outcome = (key1 == key2);
      2'b01:   outcome = (key1 <  key2);
      2'b10:   outcome = (key1 <= key2);
      default: outcome = 1'b0;
    endcase
  end

  // Result register FSM; a drain and a transfer in the same cycle keep it
  // FULL with the new result, giving one compare per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_EMPTY;
      data_q     <= 32'd0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (xfer) begin
        data_q     <= {31'd0, outcome};
        id_q       <= grant1;
        last_grant <= grant1;
      end
      case (state)
        S_EMPTY: if (xfer) state <= S_FULL;
        S_FULL:  if (!xfer && bus.resp_ready) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.resp_valid = (state == S_FULL);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;

  assign dbg_full       = (state == S_FULL);
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_fcmp_arb.sv
// Directed bench for fcmp_arb: compare vectors from a table, then
// contention, back-pressure and reset-in-flight sequences.
module tb_fcmp_arb;

  logic clk;
  logic rstn;
  logic dbg_full;
  logic dbg_last_grant;

  fcmp_arb_if bus ();

  fcmp_arb dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .dbg_full       (dbg_full),
    .dbg_last_grant (dbg_last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_x1 = 32'd0; bus.req0_x2 = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_x1 = 32'd0; bus.req1_x2 = 32'd0;
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op,
                           input logic [31:0] x1, input logic [31:0] x2);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_x1 = x1; bus.req0_x2 = x2;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_x1 = x1; bus.req1_x2 = x2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Both requesters: req0 flt 1.0<2.0 -> 1, req1 feq 1.0==2.0 -> 0.
  task automatic drive_both();
    drive_req(1'b0, 2'b01, 32'h3F80_0000, 32'h4000_0000);
    drive_req(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000);
  endtask

  initial begin
    logic [32:0] e;

    vecs[0]  = '{1'b0, 2'b01, 32'h3F80_0000, 32'h4000_0000, 1'b1};
    vecs[1]  = '{1'b0, 2'b00, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b1, 2'b01, 32'hC000_0000, 32'hBF80_0000, 1'b1};
    vecs[3]  = '{1'b0, 2'b10, 32'h3F80_0000, 32'h3F80_0000, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 32'h3F80_0000, 32'h3F80_0000, 1'b0};
    vecs[5]  = '{1'b1, 2'b11, 32'h3F80_0000, 32'h4000_0000, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 32'h4000_0000, 32'h3F80_0000, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 32'hBF80_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 32'h3F80_0000, 32'h4000_0000, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 32'h8000_0000, 32'h0000_0000, 1'b1};

    rstn = 1'b0;
    bus.resp_ready = 1'b1;
    clear_reqs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;

    // Reset state: nothing granted even with both valid.
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {32'd0, bus.resp_valid}, 33'd0);
    chk("rst_resp_data",  {1'b0, bus.resp_data}, 33'd0);
    chk("rst_resp_id",    {32'd0, bus.resp_id}, 33'd0);
    chk("rst_readys",     {31'd0, bus.req1_ready, bus.req0_ready}, 33'd0);
    chk("rst_last_grant", {32'd0, dbg_last_grant}, 33'd1);
    clear_reqs();
    @(negedge clk);
    rstn = 1'b1;

    // Table of single compares, one requester at a time.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clear_reqs();
      drive_req(vecs[i].id, vecs[i].op, vecs[i].x1, vecs[i].x2);
      exp_q.push_back({vecs[i].id, 31'd0, vecs[i].exp});
      #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.req1_ready, bus.req0_ready},
          vecs[i].id ? 33'd2 : 33'd1);
      @(negedge clk);
      clear_reqs();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_valid", i), {32'd0, bus.resp_valid}, 33'd1);
      chk($sformatf("vec%0d_result", i), {bus.resp_id, bus.resp_data}, e);
    end

    // Contention from reset: grants and results alternate 0,1,0,1.
    do_reset();
    drive_both();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready", i), {31'd0, bus.req1_ready, bus.req0_ready},
          (i % 2 == 0) ? 33'd1 : 33'd2);
      if (i > 0) begin
        chk($sformatf("rr%0d_prev_valid", i), {32'd0, bus.resp_valid}, 33'd1);
        chk($sformatf("rr%0d_prev_result", i), {bus.resp_id, bus.resp_data},
            ((i - 1) % 2 == 0) ? {1'b0, 32'd1} : {1'b1, 32'd0});
      end
      @(negedge clk);
    end
    #1;
    chk("rr_last_result", {bus.resp_id, bus.resp_data}, {1'b1, 32'd0});

    // Back-pressure: first result held three cycles, no further grants.
    do_reset();
    bus.resp_ready = 1'b0;
    drive_both();
    #1;
    chk("bp_first_ready", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_readys", k), {31'd0, bus.req1_ready, bus.req0_ready}, 33'd0);
      chk($sformatf("bp%0d_valid", k), {32'd0, bus.resp_valid}, 33'd1);
      chk($sformatf("bp%0d_hold", k), {bus.resp_id, bus.resp_data}, {1'b0, 32'd1});
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd2);
    @(negedge clk);
    #1;
    chk("bp_next_valid", {32'd0, bus.resp_valid}, 33'd1);
    chk("bp_next_result", {bus.resp_id, bus.resp_data}, {1'b1, 32'd0});

    // Reset while a result is stalled in the register.
    bus.resp_ready = 1'b0;
    #1;
    chk("mid_full_before", {32'd0, bus.resp_valid}, 33'd1);
    rstn = 1'b0;
    #1;
    chk("mid_valid_drop", {32'd0, bus.resp_valid}, 33'd0);
    chk("mid_data_clear", {bus.resp_id, bus.resp_data}, 33'd0);
    chk("mid_readys", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd0);
    chk("mid_last_grant", {32'd0, dbg_last_grant}, 33'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    chk("mid_first_grant", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd1);
    @(negedge clk);
    #1;
    chk("mid_first_result", {bus.resp_id, bus.resp_data}, {1'b0, 32'd1});
    clear_reqs();
    @(negedge clk);
    #1;
    chk("final_drain", {32'd0, bus.resp_valid}, 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
